// File: rtl/arb_mux_4_1_rr.sv
// Round-robin arbitrated 4:1 multiplexer. It picks one of four valid/ready
// requesters and registers the winner's word into a one-entry output register.
module arb_mux_4_1_rr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_vld,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [3:0]   req_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  input  logic         out_rdy,
  output logic [1:0]   sel
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   ptr_q;
  logic [1:0]   win;
  logic         has_win;
  logic         can_load;
  logic         accept;
  logic [W-1:0] win_data;

  assign out_vld  = (state_q == FULL);
  assign can_load = ~out_vld | out_rdy;
  assign accept   = |(req_vld & req_rdy);

  // Round-robin scan: the first pending requester at or after ptr wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    has_win = 1'b0;
    win     = ptr_q;
    for (int i = 0; i < 4; i++) begin
      if (!has_win && req_vld[ptr_q + 2'(i)]) begin
        has_win = 1'b1;
        win     = ptr_q + 2'(i);
      end
    end
  end

  // Grant the winner only when the output register can take a word; rst blocks all grants.
  always_comb begin
    req_rdy = 4'b0000;
    if (has_win && can_load && !rst) begin
      req_rdy[win] = 1'b1;
    end
  end

  // 4:1 data select steered by the winner index only; data never reaches control.
  always_comb begin
    win_data = d0;
    case (win)
      2'd0:    win_data = d0;
      2'd1:    win_data = d1;
      2'd2:    win_data = d2;
      default: win_data = d3;
    endcase
  end

  // Output register next state: refill wins over drain, drain empties, stall holds.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = FULL;
    end else if (out_vld && out_rdy) begin
      state_d = EMPTY;
    end
  end

  // State, data, index and priority pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      state_q  <= EMPTY;
      out_data <= '0;
      sel      <= 2'd0;
      ptr_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        out_data <= win_data;
        sel      <= win;
        ptr_q    <= win + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_4_1_rr.sv
// Self-checking bench for arb_mux_4_1_rr: a behavioural arbiter model queues
// each expected accepted word and the word is compared once the DUT registers it.
module tb_arb_mux_4_1_rr;

  localparam int W = 4;

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] data;
  } entry_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_vld;
  logic [W-1:0] d0, d1, d2, d3;
  logic [3:0]   req_rdy;
  logic         out_vld;
  logic [W-1:0] out_data;
  logic         out_rdy;
  logic [1:0]   sel;

  int tests = 0;
  int fails = 0;

  entry_t       sb_q[$];
  logic         m_vld;
  logic [W-1:0] m_data;
  logic [1:0]   m_sel;
  int           m_ptr;

  arb_mux_4_1_rr #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .d0       (d0),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .req_rdy  (req_rdy),
    .out_vld  (out_vld),
    .out_data (out_data),
    .out_rdy  (out_rdy),
    .sel      (sel)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] req_data(input int i);
    case (i)
      0:       return d0;
      1:       return d1;
      2:       return d2;
      default: return d3;
    endcase
  endfunction

  // One clock: check req_rdy mid-cycle, queue any predicted accept, then check outputs after the edge.
  task automatic step();
    logic [3:0] e_rdy;
    bit         found;
    int         w;
    int         k;
    entry_t     e;
    @(negedge clk);
    e_rdy = 4'b0000;
    found = 1'b0;
    w     = 0;
    if (!rst && (!m_vld || out_rdy)) begin
      for (int i = 0; i < 4; i++) begin
        k = (m_ptr + i) % 4;
        if (!found && req_vld[k]) begin
          found = 1'b1;
          w     = k;
        end
      end
    end
    if (found) begin
      e_rdy[w] = 1'b1;
      e.sel    = 2'(w);
      e.data   = req_data(w);
      sb_q.push_back(e);
      m_ptr = (w + 1) % 4;
    end
    check("req_rdy", 32'(req_rdy), 32'(e_rdy));
    @(posedge clk);
    #1;
    if (rst) begin
      m_vld  = 1'b0;
      m_data = '0;
      m_sel  = 2'd0;
      m_ptr  = 0;
    end else if (found) begin
      e      = sb_q.pop_front();
      m_vld  = 1'b1;
      m_data = e.data;
      m_sel  = e.sel;
    end else if (m_vld && out_rdy) begin
      m_vld = 1'b0;
    end
    check("out_vld", 32'(out_vld), 32'(m_vld));
    check("out_data", 32'(out_data), 32'(m_data));
    check("sel", 32'(sel), 32'(m_sel));
  endtask

  initial begin
    logic [1:0]   exp_sel[6];
    logic [W-1:0] exp_dat[6];
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_dat = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1, 4'd2};

    m_vld  = 1'b0;
    m_data = '0;
    m_sel  = 2'd0;
    m_ptr  = 0;
    rst     = 1'b1;
    req_vld = 4'b0000;
    out_rdy = 1'b1;
    d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;

    // Reset, then idle with out_rdy high.
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("idle_out_vld", 32'(out_vld), 32'd0);
    check("idle_out_data", 32'(out_data), 32'd0);

    // All requesters pending: rotating grants 0,1,2,3,0,1 back to back.
    req_vld = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_sel", 32'(sel), 32'(exp_sel[i]));
      check("rr_data", 32'(out_data), 32'(exp_dat[i]));
    end

    // Drain without refill: register empties, word held.
    req_vld = 4'b0000;
    step();
    check("drain_out_vld", 32'(out_vld), 32'd0);
    check("drain_data_hold", 32'(out_data), 32'd2);

    // Single requester 2 with stepping data, one word per cycle.
    req_vld = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      d2 = 4'(5 + i);
      step();
      check("single_data", 32'(out_data), 32'(5 + i));
    end
    d2 = 4'd3;

    // Capture 9 from requester 1, then stall three cycles with everyone pending.
    req_vld = 4'b0010;
    d1 = 4'd9;
    step();
    check("cap_sel", 32'(sel), 32'd1);
    req_vld = 4'b1111;
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_data", 32'(out_data), 32'd9);
      check("stall_rdy", 32'(req_rdy), 32'd0);
    end
    d1 = 4'd2;
    out_rdy = 1'b1;
    step();
    check("after_stall_sel", 32'(sel), 32'd2);

    // Grant to 3, then priority wraps to 0, then back to 3.
    step();
    check("grant3_sel", 32'(sel), 32'd3);
    req_vld = 4'b1001;
    step();
    check("wrap_sel", 32'(sel), 32'd0);
    step();
    check("wrap_next_sel", 32'(sel), 32'd3);

    // Full with sel=2 and pointer at 3, then a one-cycle reset pulse.
    req_vld = 4'b0100;
    step();
    check("pre_rst_sel", 32'(sel), 32'd2);
    req_vld = 4'b1111;
    out_rdy = 1'b0;
    rst = 1'b1;
    step();
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    out_rdy = 1'b1;
    step();
    check("post_rst_sel", 32'(sel), 32'd0);
    check("post_rst_data", 32'(out_data), 32'd1);

    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
